i2s_tx: RTL



---
 rtl/i2s_tx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S DAC transmitter: stereo word FIFO, LRC-framed MSB-first serialiser.
// Optional macro I2S_TX_REPEAT_ON_UNDERRUN_EN resends the last popped word when the FIFO runs dry.
module i2s_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          bclk,
  input  logic                          reset_n,
  input  logic                          daclrc,
  input  logic                          tx_valid,
  input  logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_ready,
  output logic                          dacdat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          slot_abort
);
  localparam int HALF  = DATA_WIDTH / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, LEFT, GAP_L, RIGHT, GAP_R} state_t;

  state_t                state_q, state_d;
  logic                  lrc_r0_q, lrc_r1_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  tx_ready_q, tx_ready_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, cnt_m1;
  logic                  dacdat_q, dacdat_d;
  logic                  underrun_q, underrun_d;
  logic                  slot_abort_q, slot_abort_d;
  logic                  left_edge, right_edge, push, pop;
  logic [HALF-1:0]       left_bits, right_bits;
  logic [DATA_WIDTH-1:0] head, fill_word;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
  logic [DATA_WIDTH-1:0] last_q, last_d;
`endif

  always_comb begin
    left_edge  = lrc_r1_q & ~lrc_r0_q;
    right_edge = ~lrc_r1_q & lrc_r0_q;
    push       = tx_valid & tx_ready_q;
    // Level before this cycle's push: a word arriving with the edge waits a frame.
    pop        = left_edge & (level_q != '0);
    head       = mem_q[rd_ptr_q];
    left_bits  = word_q[DATA_WIDTH-1:HALF];
    right_bits = word_q[HALF-1:0];
    cnt_m1     = bit_cnt_q - CNT_W'(1);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
    tx_ready_d = (level_d != LVL_W'(FIFO_DEPTH));

`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
    last_d    = pop ? head : last_q;
    fill_word = last_q;
`else
    fill_word = '0;
`endif

    state_d      = state_q;
    word_d       = word_q;
    bit_cnt_d    = bit_cnt_q;
    dacdat_d     = 1'b0;
    underrun_d   = 1'b0;
    slot_abort_d = 1'b0;

    if (left_edge) begin
      word_d       = pop ? head : fill_word;
      underrun_d   = ~pop;
      dacdat_d     = word_d[DATA_WIDTH-1];
      bit_cnt_d    = CNT_W'(HALF - 1);
      slot_abort_d = (state_q == LEFT) || (state_q == RIGHT);
      state_d      = LEFT;
    end else if (right_edge && (state_q == LEFT || state_q == GAP_L)) begin
      dacdat_d     = word_q[HALF-1];
      bit_cnt_d    = CNT_W'(HALF - 1);
      slot_abort_d = (state_q == LEFT);
      state_d      = RIGHT;
    end else begin
      case (state_q)
        LEFT: begin
          if (bit_cnt_q == '0) begin
            state_d = GAP_L;
          end else begin
            bit_cnt_d = cnt_m1;
            dacdat_d  = left_bits[cnt_m1];
          end
        end
        RIGHT: begin
          if (bit_cnt_q == '0) begin
            state_d = GAP_R;
          end else begin
            bit_cnt_d = cnt_m1;
            dacdat_d  = right_bits[cnt_m1];
          end
        end
        default: dacdat_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge bclk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lrc_r0_q     <= 1'b0;
      lrc_r1_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      tx_ready_q   <= 1'b0;
      word_q       <= '0;
      bit_cnt_q    <= '0;
      dacdat_q     <= 1'b0;
      underrun_q   <= 1'b0;
      slot_abort_q <= 1'b0;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lrc_r0_q     <= daclrc;
      lrc_r1_q     <= lrc_r0_q;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      tx_ready_q   <= tx_ready_d;
      word_q       <= word_d;
      bit_cnt_q    <= bit_cnt_d;
      dacdat_q     <= dacdat_d;
      underrun_q   <= underrun_d;
      slot_abort_q <= slot_abort_d;
`ifdef I2S_TX_REPEAT_ON_UNDERRUN_EN
      last_q       <= last_d;
`endif
      if (push) mem_q[wr_ptr_q] <= tx_data;
    end
  end

  assign tx_ready   = tx_ready_q;
  assign dacdat     = dacdat_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;
  assign slot_abort = slot_abort_q;
endmodule
